// File: rtl/argon_sim_mem.sv
// Simulation RAM + MMIO (exit, console, cycle counter) behind a valid/ready port.
// Response pulses WAIT_STATES+1 cycles after accept; one request in flight, ready low while busy/halted/done.
module argon_sim_mem #(
  parameter int          DEPTH_WORDS    = 4096,
  parameter int          WAIT_STATES    = 1,
  parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_halt,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [1:0]  i_wr_mask,
  input  logic [2:0]  i_rd_mask,
  output logic        o_rsp_valid,
  output logic [31:0] o_rd_data,
  output logic        o_err_misaligned,
  output logic        o_err_invalid_mask,
  output logic        o_err_out_of_range,
  output logic        o_console_valid,
  output logic [7:0]  o_console_char,
  output logic        o_sim_done,
  output logic [31:0] o_exit_code
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES  = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  wait_cnt;
  logic [31:0] cycle_cnt;
  logic [31:0] pend_data;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, active, in_ram, in_mmio;
  logic [31:0]   mmio_diff;
  logic [3:0]    mmio_off;
  logic [2:0]    acc_size;
  logic          err_mis, err_inv, err_oor, any_err;
  logic          do_ram_wr, do_exit, do_con;
  logic          count_en, timeout_hit;
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word, acc_rdata;
  logic [7:0]    byte_val;
  logic [15:0]   half_val;

  assign o_req_ready = (state == S_IDLE) && !i_halt && !o_sim_done && !i_reset;
  assign accept      = i_req_valid && o_req_ready;

  // Request decode, evaluated on the accept cycle only
  assign active    = (i_wr_mask != 2'b00) || (i_rd_mask != 3'b000);
  assign in_ram    = {1'b0, i_addr} < RAM_BYTES;
  assign mmio_diff = i_addr - MMIO_BASE;
  assign in_mmio   = (mmio_diff[31:4] == 28'd0);
  assign mmio_off  = mmio_diff[3:0];
  assign word_idx  = i_addr[AW+1:2];
  assign ram_word  = mem[word_idx];

  always_comb begin
    acc_size = 3'd0;
    case (i_wr_mask)
      2'b01:   acc_size = 3'd1;
      2'b10:   acc_size = 3'd2;
      2'b11:   acc_size = 3'd4;
      default: begin
        case (i_rd_mask)
          3'b001, 3'b101: acc_size = 3'd1;
          3'b010, 3'b110: acc_size = 3'd2;
          3'b011:         acc_size = 3'd4;
          default:        acc_size = 3'd0;
        endcase
      end
    endcase
  end

  assign err_inv = (i_rd_mask == 3'b100) || (i_rd_mask == 3'b111) ||
                   ((i_wr_mask != 2'b00) && (i_rd_mask != 3'b000)) ||
                   (active && in_mmio && (acc_size != 3'd4));
  assign err_mis = active && (((acc_size == 3'd2) && i_addr[0]) ||
                              ((acc_size == 3'd4) && (i_addr[1:0] != 2'b00)));
  assign err_oor = active && !in_ram && !in_mmio;
  assign any_err = err_inv || err_mis || err_oor;

  assign do_ram_wr = accept && !any_err && in_ram && (i_wr_mask != 2'b00);
  assign do_exit   = accept && !any_err && in_mmio && (i_wr_mask != 2'b00) && (mmio_off == 4'h0);
  assign do_con    = accept && !any_err && in_mmio && (i_wr_mask != 2'b00) && (mmio_off == 4'h8);

  // An exit write landing on the timeout cycle takes precedence
  assign count_en    = !i_halt && !o_sim_done;
  assign timeout_hit = count_en && (cycle_cnt == TIMEOUT_M1) && !do_exit;

  always_comb begin
    case (i_addr[1:0])
      2'b00:   byte_val = ram_word[7:0];
      2'b01:   byte_val = ram_word[15:8];
      2'b10:   byte_val = ram_word[23:16];
      default: byte_val = ram_word[31:24];
    endcase
  end
  assign half_val = i_addr[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    acc_rdata = 32'd0;
    if (!any_err && (i_rd_mask != 3'b000)) begin
      if (in_ram) begin
        case (i_rd_mask)
          3'b001:  acc_rdata = {24'd0, byte_val};
          3'b101:  acc_rdata = {{24{byte_val[7]}}, byte_val};
          3'b010:  acc_rdata = {16'd0, half_val};
          3'b110:  acc_rdata = {{16{half_val[15]}}, half_val};
          3'b011:  acc_rdata = ram_word;
          default: acc_rdata = 32'd0;
        endcase
      end else if (in_mmio && (mmio_off == 4'h4)) begin
        acc_rdata = cycle_cnt;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    o_rsp_valid = 1'b0;
    case (state)
      S_IDLE: if (accept) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (!i_halt && (wait_cnt == 4'd0)) state_next = S_RESP;
      S_RESP: begin
        o_rsp_valid = !i_halt && !timeout_hit;
        if (!i_halt) state_next = o_sim_done ? S_DONE : S_IDLE;
      end
      S_DONE:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
    if (timeout_hit) state_next = S_DONE;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt           <= 4'd0;
      cycle_cnt          <= 32'd0;
      pend_data          <= 32'd0;
      o_rd_data          <= 32'd0;
      o_err_misaligned   <= 1'b0;
      o_err_invalid_mask <= 1'b0;
      o_err_out_of_range <= 1'b0;
      o_console_valid    <= 1'b0;
      o_console_char     <= 8'd0;
      o_sim_done         <= 1'b0;
      o_exit_code        <= 32'd0;
    end else begin
      o_console_valid <= do_con;
      if (do_con) o_console_char <= i_wr_data[7:0];
      if (accept) begin
        wait_cnt  <= WAIT_LOAD;
        pend_data <= acc_rdata;
        if (err_mis) o_err_misaligned   <= 1'b1;
        if (err_inv) o_err_invalid_mask <= 1'b1;
        if (err_oor) o_err_out_of_range <= 1'b1;
      end else if ((state == S_WAIT) && !i_halt) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      // Read data only changes when a new response is presented
      if ((state_next == S_RESP) && (state != S_RESP))
        o_rd_data <= (state == S_IDLE) ? acc_rdata : pend_data;
      if (count_en && (cycle_cnt != 32'hFFFF_FFFF)) cycle_cnt <= cycle_cnt + 32'd1;
      if (do_exit) begin
        o_sim_done  <= 1'b1;
        o_exit_code <= i_wr_data;
      end else if (timeout_hit) begin
        o_sim_done  <= 1'b1;
        o_exit_code <= 32'hDEAD_0001;
      end
    end
  end

  // RAM has no reset so contents survive a bench reset
  always_ff @(posedge i_clk) begin
    if (do_ram_wr) begin
      case (i_wr_mask)
        2'b01:   mem[word_idx][{i_addr[1:0], 3'b000} +: 8] <= i_wr_data[7:0];
        2'b10:   mem[word_idx][{i_addr[1], 4'b0000} +: 16] <= i_wr_data[15:0];
        default: mem[word_idx] <= i_wr_data;
      endcase
    end
  end

endmodule

// File: tb/tb_argon_sim_mem.sv
// Bench for argon_sim_mem: directed scenarios plus randomized accesses against a byte-level memory model.
module tb_argon_sim_mem;
  localparam int          DEPTH = 64;
  localparam int          WS    = 2;
  localparam int          TO    = 50;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic        i_clk = 1'b0, i_reset = 1'b0, i_halt = 1'b0, i_req_valid = 1'b0;
  logic [31:0] i_addr = '0, i_wr_data = '0;
  logic [1:0]  i_wr_mask = '0;
  logic [2:0]  i_rd_mask = '0;
  logic        o_req_ready, o_rsp_valid, o_err_misaligned, o_err_invalid_mask, o_err_out_of_range;
  logic        o_console_valid, o_sim_done;
  logic [31:0] o_rd_data, o_exit_code;
  logic [7:0]  o_console_char;

  argon_sim_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .MMIO_BASE(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_halt(i_halt), .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready), .i_addr(i_addr), .i_wr_data(i_wr_data), .i_wr_mask(i_wr_mask),
    .i_rd_mask(i_rd_mask), .o_rsp_valid(o_rsp_valid), .o_rd_data(o_rd_data),
    .o_err_misaligned(o_err_misaligned), .o_err_invalid_mask(o_err_invalid_mask),
    .o_err_out_of_range(o_err_out_of_range), .o_console_valid(o_console_valid),
    .o_console_char(o_console_char), .o_sim_done(o_sim_done), .o_exit_code(o_exit_code));

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int rel_cyc = 0;
  logic [31:0] mm [DEPTH];
  logic [3:0]  kn [DEPTH];

  task automatic do_reset;
    @(negedge i_clk);
    i_reset = 1'b1; i_req_valid = 1'b0; i_halt = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    rel_cyc = cyc;
  endtask

  // Drives one request; reports response data, cycles from accept to response, console pulses seen.
  task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wm,
                      input logic [2:0] rm, input int hc, output logic [31:0] rd,
                      output int lat, output int con, output int acc, output bit ok);
    int n;
    rd = '0; lat = 0; con = 0; acc = 0; ok = 1'b0; n = 0;
    @(negedge i_clk);
    i_addr = a; i_wr_data = wd; i_wr_mask = wm; i_rd_mask = rm; i_req_valid = 1'b1;
    #1;
    while (!o_req_ready && n < 20) begin @(negedge i_clk); #1; n++; end
    if (!o_req_ready) begin i_req_valid = 1'b0; return; end
    acc = cyc;
    @(posedge i_clk);
    while (lat < 50) begin
      @(negedge i_clk);
      i_req_valid = 1'b0;
      lat++;
      i_halt = (lat <= hc);
      #1;
      if (o_console_valid) con++;
      if (o_rsp_valid) begin rd = o_rd_data; ok = 1'b1; i_halt = 1'b0; return; end
    end
    i_halt = 1'b0;
  endtask

  // Reference: byte-addressed memory with a known-byte map; returns expected data and error classes.
  function automatic void model(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wm,
                                input logic [2:0] rm, output logic [31:0] exp_d, output bit chk_d,
                                output bit mis, output bit inv, output bit oor);
    int sz, w, lane;
    bit act, inram, inmmio;
    logic [31:0] v;
    act    = (wm != 0) || (rm != 0);
    inram  = a < 4 * DEPTH;
    inmmio = (a >= BASE) && (a <= BASE + 15);
    if (wm == 1) sz = 1; else if (wm == 2) sz = 2; else if (wm == 3) sz = 4;
    else if (rm == 1 || rm == 5) sz = 1; else if (rm == 2 || rm == 6) sz = 2;
    else if (rm == 3) sz = 4; else sz = 0;
    inv = (rm == 4) || (rm == 7) || (wm != 0 && rm != 0) || (act && inmmio && sz != 4);
    mis = act && ((sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0));
    oor = act && !inram && !inmmio;
    exp_d = '0; chk_d = 1'b1; v = '0;
    if (inv || mis || oor || !inram) return;
    w = int'(a / 4); lane = int'(a % 4);
    if (wm != 0) begin
      for (int b = 0; b < sz; b++) begin
        mm[w][8*(lane+b) +: 8] = wd[8*b +: 8];
        kn[w][lane+b] = 1'b1;
      end
    end else if (rm != 0) begin
      for (int b = 0; b < sz; b++) begin
        if (!kn[w][lane+b]) chk_d = 1'b0;
        v[8*b +: 8] = mm[w][8*(lane+b) +: 8];
      end
      if (rm == 5 && v[7])  v = v | 32'hFFFF_FF00;
      if (rm == 6 && v[15]) v = v | 32'hFFFF_0000;
      exp_d = v;
    end
  endfunction

  task automatic test_reset;
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    checks++;
    if ({o_req_ready, o_rsp_valid, o_err_misaligned, o_err_invalid_mask, o_err_out_of_range,
         o_console_valid, o_sim_done} !== 7'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000000", {o_req_ready, o_rsp_valid,
        o_err_misaligned, o_err_invalid_mask, o_err_out_of_range, o_console_valid, o_sim_done});
    end
    checks++;
    if ({o_rd_data, o_exit_code, o_console_char} !== 72'd0) begin
      errors++; $display("FAIL reset_data: rd %h exit %h char %h want 0", o_rd_data, o_exit_code, o_console_char);
    end
    do_reset;
    #1;
    checks++;
    if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_req_ready); end
  endtask

  task automatic test_basic;
    logic [31:0] rd; int lat, con, acc; bit ok;
    do_reset;
    xact(32'h10, 32'hCAFE_F00D, 2'b11, 3'b000, 0, rd, lat, con, acc, ok);
    checks++;
    if (!ok || lat != WS + 1) begin errors++; $display("FAIL wr_lat: got %0d ok %0b want %0d", lat, ok, WS + 1); end
    xact(32'h10, 32'h0, 2'b00, 3'b011, 0, rd, lat, con, acc, ok);
    checks++;
    if (!ok || lat != WS + 1 || rd !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rd_word: got %h lat %0d want CAFEF00D lat %0d", rd, lat, WS + 1);
    end
    @(negedge i_clk); #1;
    checks++;
    if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_pulse_width: got %b want 0", o_rsp_valid); end
    checks++;
    if (o_rd_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_hold: got %h want CAFEF00D", o_rd_data); end
    xact(32'h13, 32'h80, 2'b01, 3'b000, 0, rd, lat, con, acc, ok);
    xact(32'h13, 32'h0, 2'b00, 3'b101, 0, rd, lat, con, acc, ok);
    checks++;
    if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL rd_sbyte: got %h want FFFFFF80", rd); end
    xact(32'h13, 32'h0, 2'b00, 3'b001, 0, rd, lat, con, acc, ok);
    checks++;
    if (rd !== 32'h0000_0080) begin errors++; $display("FAIL rd_ubyte: got %h want 00000080", rd); end
    xact(32'h10, 32'h0, 2'b00, 3'b011, 0, rd, lat, con, acc, ok);
    checks++;
    if (rd !== 32'h80FE_F00D) begin errors++; $display("FAIL rd_word_merged: got %h want 80FEF00D", rd); end
    do_reset;
    xact(32'h11, 32'h0, 2'b00, 3'b010, 0, rd, lat, con, acc, ok);
    checks++;
    if (!ok || rd !== 32'h0 || o_err_misaligned !== 1'b1) begin
      errors++; $display("FAIL misaligned_half: ok %0b rd %h flag %b want 1 0 1", ok, rd, o_err_misaligned);
    end
    xact(32'h10, 32'h0, 2'b00, 3'b011, 0, rd, lat, con, acc, ok);
    checks++;
    if (rd !== 32'h80FE_F00D || o_err_misaligned !== 1'b1 || o_err_invalid_mask !== 1'b0) begin
      errors++; $display("FAIL sticky_mis: rd %h mis %b inv %b want 80FEF00D 1 0", rd, o_err_misaligned, o_err_invalid_mask);
    end
  endtask

  task automatic test_mmio;
    logic [31:0] rd; int lat, con, acc; bit ok;
    do_reset;
    xact(BASE + 32'h8, 32'h41, 2'b11, 3'b000, 0, rd, lat, con, acc, ok);
    checks++;
    if (con != 1 || o_console_char !== 8'h41) begin
      errors++; $display("FAIL console: pulses %0d char %h want 1 41", con, o_console_char);
    end
    xact(BASE + 32'hC, 32'h0, 2'b00, 3'b011, 0, rd, lat, con, acc, ok);
    checks++;
    if (!ok || rd !== 32'h0 || {o_err_misaligned, o_err_invalid_mask, o_err_out_of_range} !== 3'b000) begin
      errors++; $display("FAIL mmio_c_read: rd %h flags %b want 0 000", rd, {o_err_misaligned, o_err_invalid_mask, o_err_out_of_range});
    end
    xact(BASE + 32'h8, 32'h42, 2'b01, 3'b000, 0, rd, lat, con, acc, ok);
    checks++;
    if (con != 0 || o_err_invalid_mask !== 1'b1 || o_console_char !== 8'h41) begin
      errors++; $display("FAIL mmio_byte: pulses %0d inv %b char %h want 0 1 41", con, o_err_invalid_mask, o_console_char);
    end
    xact(BASE, 32'd7, 2'b11, 3'b000, 0, rd, lat, con, acc, ok);
    @(negedge i_clk); #1;
    checks++;
    if (!ok || o_sim_done !== 1'b1 || o_exit_code !== 32'd7 || o_req_ready !== 1'b0) begin
      errors++; $display("FAIL exit: ok %0b done %b code %h ready %b want 1 1 7 0", ok, o_sim_done, o_exit_code, o_req_ready);
    end
  endtask

  task automatic test_counter;
    logic [31:0] rd; int lat, con, acc; bit ok;
    do_reset;
    for (int i = 0; i < 2; i++) begin
      xact(BASE + 32'h4, 32'h0, 2'b00, 3'b011, i, rd, lat, con, acc, ok);
      checks++;
      if (!ok || rd !== 32'(acc - rel_cyc)) begin
        errors++; $display("FAIL counter_%0d: got %0d want %0d", i, rd, acc - rel_cyc);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; int lat, con, acc, seen; bit ok;
    do_reset;
    xact(32'h20, 32'h1234_5678, 2'b11, 3'b000, 0, rd, lat, con, acc, ok);
    xact(32'h20, 32'h0, 2'b00, 3'b011, 0, rd, lat, con, acc, ok);
    @(negedge i_clk);
    i_addr = 32'h24; i_wr_data = 32'hA5A5_5A5A; i_wr_mask = 2'b11; i_rd_mask = 3'b000; i_req_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_rd_data !== 32'h0 || o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_out: rd %h rsp %b rdy %b want 0 0 0", o_rd_data, o_rsp_valid, o_req_ready);
    end
    seen = 0;
    repeat (2) begin @(negedge i_clk); #1; if (o_rsp_valid) seen++; end
    i_reset = 1'b0;
    rel_cyc = cyc;
    repeat (6) begin @(negedge i_clk); #1; if (o_rsp_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_reset_rsp: got %0d pulses want 0", seen); end
    xact(32'h24, 32'h0, 2'b00, 3'b011, 0, rd, lat, con, acc, ok);
    checks++;
    if (rd !== 32'hA5A5_5A5A) begin errors++; $display("FAIL mid_reset_write: got %h want A5A55A5A", rd); end
    xact(32'h20, 32'h0, 2'b00, 3'b011, 0, rd, lat, con, acc, ok);
    checks++;
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL mid_reset_keep: got %h want 12345678", rd); end
  endtask

  task automatic test_timeout;
    int k;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset;
      k = 0;
      while (k < 120) begin
        @(negedge i_clk);
        k++;
        if (pass == 1 && k == 5)  i_halt = 1'b1;
        if (pass == 1 && k == 15) i_halt = 1'b0;
        #1;
        if (o_sim_done) break;
      end
      checks++;
      if (k != TO + 10 * pass || o_exit_code !== 32'hDEAD_0001 || o_req_ready !== 1'b0) begin
        errors++; $display("FAIL timeout_%0d: cycle %0d code %h rdy %b want %0d DEAD0001 0",
                           pass, k, o_exit_code, o_req_ready, TO + 10 * pass);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rd, exp_d; logic [1:0] wm; logic [2:0] rm;
    int lat, con, acc, hc, kind; bit ok, chk_d, mis, inv, oor, s_mis, s_inv, s_oor;
    for (int w = 0; w < DEPTH; w++) kn[w] = 4'b0000;
    for (int batch = 0; batch < 6; batch++) begin
      do_reset;
      s_mis = 0; s_inv = 0; s_oor = 0;
      for (int t = 0; t < 6; t++) begin
        wm = 2'b00; rm = 3'b000;
        kind = $urandom_range(0, 9);
        if (kind < 4) wm = 2'($urandom_range(1, 3));
        else if (kind < 8) begin
          case ($urandom_range(0, 4))
            0: rm = 3'b001; 1: rm = 3'b010; 2: rm = 3'b011; 3: rm = 3'b101; default: rm = 3'b110;
          endcase
        end else if (kind == 8) begin
          if ($urandom_range(0, 1) == 1) rm = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b111;
          else begin wm = 2'($urandom_range(1, 3)); rm = 3'b011; end
        end
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
          if (wm == 2'b11 || rm == 3'b011) a[1:0] = 2'b00;
          else if (wm == 2'b10 || rm == 3'b010 || rm == 3'b110) a[0] = 1'b0;
        end
        if ($urandom_range(0, 9) == 0) a = 32'h100 + 32'($urandom_range(0, 255));
        wd = $urandom;
        hc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        model(a, wd, wm, rm, exp_d, chk_d, mis, inv, oor);
        s_mis |= mis; s_inv |= inv; s_oor |= oor;
        xact(a, wd, wm, rm, hc, rd, lat, con, acc, ok);
        checks++;
        if (!ok || lat != WS + 1 + hc) begin
          errors++; $display("FAIL rand_lat: addr %h got %0d ok %0b want %0d", a, lat, ok, WS + 1 + hc);
        end
        checks++;
        if ({o_err_misaligned, o_err_invalid_mask, o_err_out_of_range} !== {s_mis, s_inv, s_oor}) begin
          errors++; $display("FAIL rand_flags: addr %h wm %b rm %b got %b want %b", a, wm, rm,
            {o_err_misaligned, o_err_invalid_mask, o_err_out_of_range}, {s_mis, s_inv, s_oor});
        end
        if (chk_d) begin
          checks++;
          if (rd !== exp_d) begin
            errors++; $display("FAIL rand_data: addr %h wm %b rm %b got %h want %h", a, wm, rm, rd, exp_d);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_counter;
    test_random;
    test_reset_mid;
    test_mmio;
    test_timeout;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
